// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared MEM/WB types, result-select and load funct3 encodings
package pipeline_pkg;
   localparam int XLEN_C    = 32;
   localparam int RADDR_W_C = 5;
   localparam int ALO_W_C   = $clog2(XLEN_C / 8);
   localparam logic [1:0] RS_ALU  = 2'd0;
   localparam logic [1:0] RS_LOAD = 2'd1;
   localparam logic [1:0] RS_PC4  = 2'd2;
   localparam logic [1:0] RS_IMM  = 2'd3;
   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LD   = 3'b011;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_LWU  = 3'b110;
   typedef struct packed {
      logic                 valid;
      logic                 RegWrite;
      logic [RADDR_W_C-1:0] Rd;
      logic [1:0]           ResultSrc;
      logic                 is_load;
      logic [2:0]           funct3;
      logic [ALO_W_C-1:0]   addr_lo;
      logic [XLEN_C-1:0]    ALUResult;
      logic [XLEN_C-1:0]    PCPlus4;
      logic [XLEN_C-1:0]    ImmExt;
   } memwb_mc_t;
   typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;
endpackage

// File: rtl/mux4.sv
// mux4: generic 4:1 multiplexer
module mux4 #(parameter int W = 32) (
   input  logic [1:0]   sel,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   output logic [W-1:0] y
);
   assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/wb_stage_mc_load_extend.sv
// load_extend: byte/half/word lane extraction with sign or zero extension
module load_extend import pipeline_pkg::*; #(parameter int XLEN = 32) (
   input  logic [XLEN-1:0]              rdata,
   input  logic [2:0]                   funct3,
   input  logic [$clog2(XLEN/8)-1:0]    addr_lo,
   output logic [XLEN-1:0]              ext_data
);
   localparam int AW = $clog2(XLEN / 8);
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] w;
   assign b = 8'(rdata >> {addr_lo, 3'b000});
   assign h = 16'(rdata >> {addr_lo[AW-1:1], 4'b0000});
   // On RV32 the only word lane is lane 0
   assign w = (XLEN == 64) ? 32'(rdata >> {addr_lo[AW-1], 5'b00000}) : 32'(rdata);
   assign ext_data = (funct3 == F3_LB)  ? XLEN'($signed(b)) :
                     (funct3 == F3_LBU) ? XLEN'(b) :
                     (funct3 == F3_LH)  ? XLEN'($signed(h)) :
                     (funct3 == F3_LHU) ? XLEN'(h) :
                     (funct3 == F3_LW)  ? XLEN'($signed(w)) :
                     (funct3 == F3_LWU && XLEN == 64) ? XLEN'(w) :
                     rdata;
endmodule

// File: rtl/wb_stage_mc.sv
// wb_stage_mc: write-back stage with variable-latency load return, stall
// handshake, x0 write suppression and retired-instruction counter
module wb_stage_mc import pipeline_pkg::*; #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  memwb_mc_t          inputs,
   input  logic               load_rvalid,
   input  logic [XLEN-1:0]    load_rdata,
   output logic               RegWriteW,
   output logic [RADDR_W-1:0] RdW,
   output logic [XLEN-1:0]    ResultW,
   output logic               wb_stall,
   output logic               spurious_rsp,
   output logic [CNT_W-1:0]   instret
);
   localparam int AW = $clog2(XLEN / 8);
   wb_state_e state, state_d;
   logic [RADDR_W-1:0] rd_q, rd;
   logic               rw_q, rw;
   logic [2:0]         f3_q, f3;
   logic [AW-1:0]      al_q, al;
   logic [1:0]         rs_q, rs;
   logic               commit, stall, spur, latch;
   logic [XLEN-1:0]    ext;
   always_comb begin
      state_d = state;
      commit  = 1'b0;
      stall   = 1'b0;
      spur    = 1'b0;
      latch   = 1'b0;
      rd      = inputs.Rd;
      rw      = inputs.RegWrite;
      f3      = inputs.funct3;
      al      = inputs.addr_lo;
      rs      = inputs.ResultSrc;
      if (state == IDLE) begin
         spur = load_rvalid && !(inputs.valid && inputs.is_load);
         if (inputs.valid && (!inputs.is_load || load_rvalid)) commit = 1'b1;
         else if (inputs.valid) begin
            stall   = 1'b1;
            latch   = 1'b1;
            state_d = WAIT_LOAD;
         end
      end else begin
         // Upstream is frozen: everything comes from the latch
         rd      = rd_q;
         rw      = rw_q;
         f3      = f3_q;
         al      = al_q;
         rs      = rs_q;
         commit  = load_rvalid;
         stall   = !load_rvalid;
         state_d = load_rvalid ? IDLE : WAIT_LOAD;
      end
   end
   load_extend #(.XLEN(XLEN)) u_ext (.rdata(load_rdata), .funct3(f3), .addr_lo(al), .ext_data(ext));
   mux4 #(.W(XLEN)) u_mux (
      .sel(rs), .d0(inputs.ALUResult), .d1(ext), .d2(inputs.PCPlus4), .d3(inputs.ImmExt), .y(ResultW)
   );
   assign RdW          = rd;
   assign RegWriteW    = !reset && commit && rw && (rd != '0);
   assign wb_stall     = !reset && stall;
   assign spurious_rsp = !reset && spur;
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         instret <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         f3_q    <= '0;
         al_q    <= '0;
         rs_q    <= '0;
      end else begin
         state <= state_d;
         if (commit) instret <= instret + CNT_W'(1);
         if (latch) begin
            rd_q <= inputs.Rd;
            rw_q <= inputs.RegWrite;
            f3_q <= inputs.funct3;
            al_q <= inputs.addr_lo;
            rs_q <= inputs.ResultSrc;
         end
      end
   end
endmodule

// File: tb/tb_wb_stage_mc.sv
// tb_wb_stage_mc: directed-vector bench for the write-back stage and a
// standalone 64-bit load_extend
module tb_wb_stage_mc;
   import pipeline_pkg::*;
   logic        clk = 0;
   logic        reset;
   memwb_mc_t   in_s;
   logic        load_rvalid;
   logic [31:0] load_rdata;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic        wb_stall;
   logic        spurious_rsp;
   logic [63:0] instret;
   logic [63:0] rd64, ext64;
   logic [2:0]  f3_64;
   logic [2:0]  al64;
   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   wb_stage_mc #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
      .clk(clk), .reset(reset), .inputs(in_s), .load_rvalid(load_rvalid), .load_rdata(load_rdata),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .wb_stall(wb_stall),
      .spurious_rsp(spurious_rsp), .instret(instret)
   );

   load_extend #(.XLEN(64)) u_ext64 (.rdata(rd64), .funct3(f3_64), .addr_lo(al64), .ext_data(ext64));

   task automatic clear_in();
      in_s = '0;
      load_rvalid = 1'b0;
      load_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_in();
      reset = 1'b1;
      in_s.valid = 1'b1; in_s.is_load = 1'b1; in_s.RegWrite = 1'b1; in_s.Rd = 5'd4;
      #1;
      vecs++;
      if (RegWriteW !== 1'b0 || wb_stall !== 1'b0 || spurious_rsp !== 1'b0) begin
         errs++; $display("FAIL reset_outputs: got rw=%b stall=%b spur=%b, want 0 0 0", RegWriteW, wb_stall, spurious_rsp);
      end
      tick(); tick();
      vecs++;
      if (instret !== 64'd0) begin errs++; $display("FAIL reset_instret: got %0d want 0", instret); end
      clear_in();
      reset = 1'b0;
      #1;
      vecs++;
      if (RegWriteW !== 1'b0 || wb_stall !== 1'b0) begin
         errs++; $display("FAIL idle_invalid: got rw=%b stall=%b want 0 0", RegWriteW, wb_stall);
      end
      tick();
   endtask

   task automatic test_alu();
      clear_in();
      in_s.valid = 1'b1; in_s.RegWrite = 1'b1; in_s.Rd = 5'd5; in_s.ResultSrc = RS_ALU;
      in_s.ALUResult = 32'h0000_1234; in_s.PCPlus4 = 32'h0000_0AAA;
      #1;
      vecs++;
      if (RegWriteW !== 1'b1 || RdW !== 5'd5 || ResultW !== 32'h1234 || wb_stall !== 1'b0) begin
         errs++; $display("FAIL add: got rw=%b rd=%0d res=%h stall=%b want 1 5 00001234 0", RegWriteW, RdW, ResultW, wb_stall);
      end
      tick();
      vecs++;
      if (instret !== 64'd1) begin errs++; $display("FAIL add_instret: got %0d want 1", instret); end
   endtask

   task automatic test_load_zero_latency();
      logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b010, 3'b101, 3'b111, 3'b110};
      logic [1:0]  als [6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
      logic [31:0] rds [6] = '{32'h0080_0000, 32'h0080_0000, 32'hDEAD_BEEF, 32'h1234_F00D, 32'h1234_5678, 32'h8765_4321};
      logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0000_F00D, 32'h1234_5678, 32'h8765_4321};
      for (int i = 0; i < 6; i++) begin
         clear_in();
         in_s.valid = 1'b1; in_s.is_load = 1'b1; in_s.RegWrite = 1'b1; in_s.Rd = 5'd10;
         in_s.ResultSrc = RS_LOAD; in_s.funct3 = f3s[i]; in_s.addr_lo = als[i];
         load_rvalid = 1'b1; load_rdata = rds[i];
         #1;
         vecs++;
         if (ResultW !== exp[i] || RegWriteW !== 1'b1 || wb_stall !== 1'b0 || spurious_rsp !== 1'b0) begin
            errs++; $display("FAIL zl_load[%0d]: got res=%h rw=%b stall=%b spur=%b want %h 1 0 0", i, ResultW, RegWriteW, wb_stall, spurious_rsp, exp[i]);
         end
         tick();
      end
      vecs++;
      if (instret !== 64'd7) begin errs++; $display("FAIL zl_instret: got %0d want 7", instret); end
   endtask

   task automatic test_load_stall();
      clear_in();
      in_s.valid = 1'b1; in_s.is_load = 1'b1; in_s.RegWrite = 1'b1; in_s.Rd = 5'd7;
      in_s.ResultSrc = RS_LOAD; in_s.funct3 = F3_LH; in_s.addr_lo = 2'd2;
      for (int c = 0; c < 3; c++) begin
         #1;
         vecs++;
         if (wb_stall !== 1'b1 || RegWriteW !== 1'b0) begin
            errs++; $display("FAIL lh_stall[%0d]: got stall=%b rw=%b want 1 0", c, wb_stall, RegWriteW);
         end
         tick();
         // live inputs change while frozen; the latched load must win
         in_s.Rd = 5'd9; in_s.funct3 = F3_LBU; in_s.addr_lo = 2'd0; in_s.ResultSrc = RS_ALU;
      end
      load_rvalid = 1'b1; load_rdata = 32'h8001_0000;
      #1;
      vecs++;
      if (RegWriteW !== 1'b1 || RdW !== 5'd7 || ResultW !== 32'hFFFF_8001 || wb_stall !== 1'b0) begin
         errs++; $display("FAIL lh_commit: got rw=%b rd=%0d res=%h stall=%b want 1 7 ffff8001 0", RegWriteW, RdW, ResultW, wb_stall);
      end
      tick();
      vecs++;
      if (instret !== 64'd8) begin errs++; $display("FAIL lh_instret: got %0d want 8", instret); end
   endtask

   task automatic test_rd0_imm();
      clear_in();
      in_s.valid = 1'b1; in_s.RegWrite = 1'b1; in_s.Rd = 5'd0; in_s.ResultSrc = RS_PC4; in_s.PCPlus4 = 32'h104;
      #1;
      vecs++;
      if (RegWriteW !== 1'b0 || ResultW !== 32'h104) begin
         errs++; $display("FAIL rd0: got rw=%b res=%h want 0 00000104", RegWriteW, ResultW);
      end
      tick();
      vecs++;
      if (instret !== 64'd9) begin errs++; $display("FAIL rd0_instret: got %0d want 9", instret); end
      in_s.Rd = 5'd3; in_s.ResultSrc = RS_IMM; in_s.ImmExt = 32'hABC0_0000;
      #1;
      vecs++;
      if (RegWriteW !== 1'b1 || RdW !== 5'd3 || ResultW !== 32'hABC0_0000) begin
         errs++; $display("FAIL imm: got rw=%b rd=%0d res=%h want 1 3 abc00000", RegWriteW, RdW, ResultW);
      end
      tick();
      vecs++;
      if (instret !== 64'd10) begin errs++; $display("FAIL imm_instret: got %0d want 10", instret); end
   endtask

   task automatic test_reset_mid_wait();
      clear_in();
      in_s.valid = 1'b1; in_s.is_load = 1'b1; in_s.RegWrite = 1'b1; in_s.Rd = 5'd8;
      in_s.ResultSrc = RS_LOAD; in_s.funct3 = F3_LW;
      tick();
      #1;
      vecs++;
      if (wb_stall !== 1'b1) begin errs++; $display("FAIL wait_stall: got %b want 1", wb_stall); end
      reset = 1'b1;
      #1;
      vecs++;
      if (wb_stall !== 1'b0 || RegWriteW !== 1'b0) begin
         errs++; $display("FAIL reset_in_wait: got stall=%b rw=%b want 0 0", wb_stall, RegWriteW);
      end
      tick();
      reset = 1'b0;
      clear_in();
      #1;
      vecs++;
      if (wb_stall !== 1'b0 || instret !== 64'd0) begin
         errs++; $display("FAIL post_reset: got stall=%b instret=%0d want 0 0", wb_stall, instret);
      end
      load_rvalid = 1'b1; load_rdata = 32'h1111_2222;
      #1;
      vecs++;
      if (spurious_rsp !== 1'b1 || RegWriteW !== 1'b0) begin
         errs++; $display("FAIL late_rsp: got spur=%b rw=%b want 1 0", spurious_rsp, RegWriteW);
      end
      tick();
      clear_in();
      #1;
      vecs++;
      if (instret !== 64'd0 || spurious_rsp !== 1'b0 || wb_stall !== 1'b0) begin
         errs++; $display("FAIL after_spur: got instret=%0d spur=%b stall=%b want 0 0 0", instret, spurious_rsp, wb_stall);
      end
   endtask

   task automatic test_extend64();
      logic [2:0]  f3s [5] = '{3'b110, 3'b010, 3'b011, 3'b000, 3'b101};
      logic [2:0]  als [5] = '{3'd4, 3'd4, 3'd0, 3'd7, 3'd6};
      logic [63:0] exp [5] = '{64'h0000_0000_F000_0000, 64'hFFFF_FFFF_F000_0000,
                               64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_F000};
      for (int i = 0; i < 5; i++) begin
         rd64 = 64'hF000_0000_0000_0000; f3_64 = f3s[i]; al64 = als[i];
         #1;
         vecs++;
         if (ext64 !== exp[i]) begin
            errs++; $display("FAIL ext64[%0d]: got %h want %h", i, ext64, exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_zero_latency();
      test_load_stall();
      test_rd0_imm();
      test_reset_mid_wait();
      test_extend64();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/wb_stage_mc.md
Name: wb_stage_mc

Overview:
- Parametrised write-back stage for the RV32I/RV64I pipeline; successor to the single-cycle write-back mux.
- Adds variable-latency load return with a stall handshake, byte/half/word(/double) load extraction with sign/zero extension, an x0 write-suppress, and a 64-bit retired-instruction counter.
- Sits after the MEM/WB pipeline register and drives the register-file write port and the hazard unit's WB stall input.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RADDR_W, 5, register index width.
- CNT_W, 64, width of the instret counter.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- inputs  in  memwb_mc_t  MEM/WB fields: valid, RegWrite, Rd[RADDR_W], ResultSrc[2], is_load, funct3[3], addr_lo[$clog2(XLEN/8)], ALUResult, PCPlus4, ImmExt (XLEN each)
- load_rvalid  in  1  data-memory response valid
- load_rdata  in  XLEN  raw aligned memory word
- RegWriteW  out  1  register-file write enable
- RdW  out  RADDR_W  destination register
- ResultW  out  XLEN  write-back data
- wb_stall  out  1  hold MEM/WB and all upstream stages
- spurious_rsp  out  1  one-cycle pulse: load_rvalid with no load pending
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, WAIT_LOAD. Reset (synchronous, active-high) -> IDLE, instret=0, latched fields cleared. During reset: RegWriteW=0, wb_stall=0, spurious_rsp=0.
- IDLE, inputs.valid=0: RegWriteW=0, no commit.
- IDLE, valid and !is_load: commit combinationally in the same cycle. ResultW uses ResultSrc: 0=ALUResult, 1=extended load, 2=PCPlus4, 3=ImmExt. RegWriteW=RegWrite && Rd!=0.
- IDLE, valid, is_load, load_rvalid=1: commit in the same cycle with the extended load_rdata. Zero latency, no stall.
- IDLE, valid, is_load, load_rvalid=0:
  - Latch Rd, RegWrite, funct3, addr_lo and ResultSrc.
  - Go to WAIT_LOAD; wb_stall=1 combinationally in this cycle.
  - RegWriteW=0.
- WAIT_LOAD, load_rvalid=0: wb_stall=1, RegWriteW=0. Live inputs are ignored because upstream is frozen.
- WAIT_LOAD, load_rvalid=1:
  - Commit from the latched fields; RdW and RegWriteW come from the latch.
  - wb_stall=0 in this same cycle, so upstream advances on this edge.
  - Go to IDLE.
  - Live inputs in this cycle are not consumed; the next instruction appears at MEM/WB on the following cycle.
- No timeout; WAIT_LOAD persists until a response or reset arrives. Reset mid-WAIT_LOAD drops the load: no write, instret not incremented.
- load_rvalid in IDLE with no valid load presented: spurious_rsp=1 for that cycle, data discarded, no state change.
- Load extraction (funct3):
  - 000 LB: sign-extend.
  - 100 LBU: zero-extend. Byte lane = addr_lo.
  - 001 LH: sign-extend.
  - 101 LHU: zero-extend. Half lane = addr_lo[msb:1].
  - 010 LW: sign-extend to XLEN. Word lane = addr_lo[msb:2] when XLEN=64.
  - 110 LWU: zero-extend; legal only when XLEN=64.
  - 011 LD: raw word; legal only when XLEN=64.
  - Any other code, or a code illegal for the XLEN: pass load_rdata unmodified.
- Misalignment is trapped upstream; this block does not check it.
- instret increments by 1 on every commit cycle with a valid instruction, including Rd=0 and RegWrite=0 instructions. Wraps modulo 2^CNT_W.

Decomposition:
- pipeline_pkg gets:
  - memwb_mc_t, a struct parametrised by the package constants XLEN_C and RADDR_W_C;
  - enum wb_state_e {IDLE, WAIT_LOAD};
  - localparams for the ResultSrc encodings and the funct3 load codes.
- One sub-module, load_extend: combinational, parameter XLEN; inputs rdata, funct3, addr_lo; output ext_data.
- Reuse the existing mux4 for result selection.

Test Plan:
- ADD: valid=1, !is_load, ResultSrc=0, ALUResult=0x0000_1234, Rd=5, RegWrite=1 -> same cycle RegWriteW=1, RdW=5, ResultW=0x1234, wb_stall=0, instret 0->1.
- Zero-latency LB: funct3=000, addr_lo=2, load_rdata=0x0080_0000, load_rvalid=1 -> ResultW=0xFFFF_FF80, no stall. Same stimulus as LBU (100) -> ResultW=0x0000_0080.
- 3-cycle LH: funct3=001, addr_lo=2, Rd=7, rvalid low 3 cycles -> wb_stall=1 and RegWriteW=0 for 3 cycles. Then rvalid with rdata=0x8001_0000 -> RegWriteW=1, RdW=7, ResultW=0xFFFF_8001, wb_stall=0 that cycle, instret +1.
- Rd=0 write: ResultSrc=2, PCPlus4=0x104, Rd=0, RegWrite=1 -> RegWriteW=0, instret still increments. ResultSrc=3 with ImmExt=0xABC0_0000 and Rd=3 -> ResultW=0xABC0_0000.
- Reset mid-WAIT_LOAD: assert reset on the 2nd stall cycle -> next cycle IDLE, wb_stall=0, instret=0. Late load_rvalid afterwards -> spurious_rsp=1 and no write.
- XLEN=64: LWU with addr_lo=4, rdata=0xF000_0000_0000_0000 -> ResultW=0x0000_0000_F000_0000. LW with the same stimulus -> 0xFFFF_FFFF_F000_0000.
